nn_frame_fifo: RTL

Parametrised, frame-aware stream buffer for neural-network stage outputs, such as the error and data-out paths between stages. It carries float_24_8 words (or any packed WIDTH) with vld/rdy/fst handshakes. It adds three things to a plain FIFO: frame-length checking, a count of complete frames held, and a synchronous flush. Stage controllers use it to decouple producer and consumer and to start back-propagation only once a full frame is buffered.

---
 rtl/nn_frame_fifo_if.sv | 28 ++
 rtl/nn_frame_fifo.sv | 92 +++++++++
 2 files changed

// File: rtl/nn_frame_fifo_if.sv
// nn_frame_fifo_if: write/read stream and status bundle for nn_frame_fifo.
interface nn_frame_fifo_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 5
);
    logic [WIDTH-1:0] in_data;
    logic             in_fst;
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] out_data;
    logic             out_fst;
    logic             out_last;
    logic             out_vld;
    logic             out_rdy;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic [CW-1:0]    frames;
    logic             frame_err;

    modport master (
        output in_data, in_fst, in_vld, out_rdy,
        input  in_rdy, out_data, out_fst, out_last, out_vld, count, almost_full, frames, frame_err
    );
    modport slave (
        input  in_data, in_fst, in_vld, out_rdy,
        output in_rdy, out_data, out_fst, out_last, out_vld, count, almost_full, frames, frame_err
    );
endinterface

// File: rtl/nn_frame_fifo.sv
// nn_frame_fifo: fall-through stream FIFO with frame-length checking,
// complete-frame count and synchronous flush.
module nn_frame_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 12,
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int CW        = $clog2(DEPTH) + 1
) (
    input logic             clk,
    input logic             reset,
    input logic             flush,
    nn_frame_fifo_if.slave  s
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] L_FLEN  = CW'(FRAME_LEN);
    localparam logic [CW-1:0] L_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] L_ONE   = CW'(1);

    logic [WIDTH:0]  r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_frames;
    logic [CW-1:0]   r_in_pos;
    logic [CW-1:0]   r_out_pos;
    logic            r_err;
    logic            r_live;
    logic            w_wr;
    logic            w_rd;
    logic            w_short;
    logic            w_long;
    logic            w_done;
    logic            w_pop_last;
    logic [CW-1:0]   w_in_nxt;
    logic [CW-1:0]   w_out_nxt;

    // r_live holds in_rdy low until the first clock after reset release
    assign s.in_rdy      = r_live && (r_count != L_DEPTH);
    assign s.out_vld     = r_count != '0;
    assign {s.out_fst, s.out_data} = r_mem[r_rd];
    assign s.count       = r_count;
    assign s.frames      = r_frames;
    assign s.almost_full = r_count >= L_AF;
    assign s.frame_err   = r_err;

    assign w_wr       = s.in_vld && s.in_rdy && !flush;
    assign w_rd       = s.out_vld && s.out_rdy && !flush;
    assign w_short    = s.in_fst && (r_in_pos != '0) && (r_in_pos < L_FLEN);
    assign w_long     = !s.in_fst && ((r_in_pos == '0) || (r_in_pos == L_FLEN));
    assign w_in_nxt   = s.in_fst ? L_ONE : w_long ? L_FLEN : r_in_pos + L_ONE;
    // a saturated (malformed) word is not a frame completion
    assign w_done     = w_wr && !w_long && (w_in_nxt == L_FLEN);
    assign w_out_nxt  = s.out_fst ? L_ONE : r_out_pos + L_ONE;
    assign s.out_last = s.out_vld && (w_out_nxt == L_FLEN);
    assign w_pop_last = w_rd && s.out_last;

    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wr] <= {s.in_fst, s.in_data};

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_count   <= '0;
            r_frames  <= '0;
            r_in_pos  <= '0;
            r_out_pos <= '0;
            r_err     <= 1'b0;
            r_live    <= 1'b0;
        end else if (flush) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_count   <= '0;
            r_frames  <= '0;
            r_in_pos  <= '0;
            r_out_pos <= '0;
            r_err     <= 1'b0;
            r_live    <= 1'b1;
        end else begin
            r_live    <= 1'b1;
            r_wr      <= w_wr ? r_wr + AW'(1) : r_wr;
            r_rd      <= w_rd ? r_rd + AW'(1) : r_rd;
            r_count   <= r_count + CW'(w_wr) - CW'(w_rd);
            r_in_pos  <= w_wr ? w_in_nxt : r_in_pos;
            r_out_pos <= w_rd ? w_out_nxt : r_out_pos;
            r_err     <= r_err || (w_wr && (w_short || w_long));
            r_frames  <= (w_done && !w_pop_last) ? r_frames + L_ONE :
                         (w_pop_last && !w_done && r_frames != '0) ? r_frames - L_ONE : r_frames;
        end
endmodule
